// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the word at PC through a shared, granted memory
// port, holds it with decoded fields, and hands it to decode over valid/ready.
module fetch_unit #(
  parameter int RESET_PC = 20,
  parameter int DEPTH    = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  MAR,
  output logic        mem_EN,
  output logic        mem_CS,
  input  logic [23:0] mem_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [23:0] IR,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [7:0]  operand,
  output logic [2:0]  mode,
  output logic [7:0]  instr_pc,
  output logic        instr_illegal
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0] pc;
  logic [7:0] pc_seq;
  logic       take_redirect;
  logic       unused_redirect_msb;

  assign unused_redirect_msb = redirect_addr[7];

  // Redirect only matters once the fetch loop is running; IDLE ignores it.
  assign take_redirect = redirect && (state != IDLE);
  assign pc_seq        = (pc == 8'(DEPTH - 1)) ? 8'd0 : pc + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = ISSUE;
      ISSUE:   next_state = (mem_gnt && !take_redirect) ? CAPTURE : ISSUE;
      CAPTURE: next_state = take_redirect ? ISSUE : HOLD;
      HOLD:    next_state = (take_redirect || instr_ready) ? ISSUE : HOLD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_EN  = 1'b0;
    mem_CS  = 1'b0;
    if (state == ISSUE) begin
      mem_req = 1'b1;
      mem_EN  = mem_gnt;
    end
  end

  // A redirect discards any in-flight read or held instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 8'(RESET_PC);
      IR          <= 24'd0;
      instr_pc    <= 8'd0;
      instr_valid <= 1'b0;
    end else if (take_redirect) begin
      pc          <= {1'b0, redirect_addr[6:0]};
      instr_valid <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          IR          <= mem_data;
          instr_pc    <= pc;
          pc          <= pc_seq;
          instr_valid <= 1'b1;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign MAR           = pc;
  assign opcode        = IR[18:15];
  assign rd            = IR[14:11];
  assign operand       = IR[10:3];
  assign mode          = IR[2:0];
  assign instr_illegal = instr_valid && ((IR[23:19] != 5'd0) || (mode > 3'd4));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a second instance starting at PC 127 covers
// the wrap-around while the main instance walks through the handshake cases.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_gnt;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;

  logic [7:0]  MAR, MAR2;
  logic        mem_EN, mem_EN2, mem_CS, mem_CS2;
  logic [23:0] mem_data, mem_data2;
  logic        mem_req, mem_req2;
  logic        instr_valid, instr_valid2;
  logic [23:0] IR, IR2;
  logic [3:0]  opcode, opcode2, rd, rd2;
  logic [7:0]  operand, operand2;
  logic [2:0]  mode, mode2;
  logic [7:0]  instr_pc, instr_pc2;
  logic        instr_illegal, instr_illegal2;

  logic [23:0] mem [0:127];

  int errors;
  int checks;

  fetch_unit #(.RESET_PC(20), .DEPTH(128)) dut (
    .clk(clk), .reset(reset), .MAR(MAR), .mem_EN(mem_EN), .mem_CS(mem_CS),
    .mem_data(mem_data), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .IR(IR),
    .opcode(opcode), .rd(rd), .operand(operand), .mode(mode),
    .instr_pc(instr_pc), .instr_illegal(instr_illegal)
  );

  fetch_unit #(.RESET_PC(127), .DEPTH(128)) dut2 (
    .clk(clk), .reset(reset), .MAR(MAR2), .mem_EN(mem_EN2), .mem_CS(mem_CS2),
    .mem_data(mem_data2), .mem_req(mem_req2), .mem_gnt(mem_gnt),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid2), .instr_ready(instr_ready), .IR(IR2),
    .opcode(opcode2), .rd(rd2), .operand(operand2), .mode(mode2),
    .instr_pc(instr_pc2), .instr_illegal(instr_illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency synchronous memory shared by both instances.
  always @(posedge clk) begin
    if (mem_EN)  mem_data  <= mem[MAR[6:0]];
    if (mem_EN2) mem_data2 <= mem[MAR2[6:0]];
  end

  // Advance one clock, then drive the inputs for the new cycle and let them settle.
  task automatic applyStimulus(input logic rst, input logic gnt, input logic rdy,
                               input logic rdr, input logic [7:0] raddr);
    @(posedge clk);
    #1;
    reset         = rst;
    mem_gnt       = gnt;
    instr_ready   = rdy;
    redirect      = rdr;
    redirect_addr = raddr;
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    mem_gnt       = 1'b1;
    instr_ready   = 1'b1;
    redirect      = 1'b0;
    redirect_addr = 8'd0;
    mem_data      = 24'd0;
    mem_data2     = 24'd0;
    for (int i = 0; i < 128; i++) mem[i] = 24'd0;
    mem[20]  = 24'h0188F0;
    mem[21]  = 24'h07FFFC;
    mem[22]  = 24'hF80000;
    mem[23]  = 24'h111111;
    mem[24]  = 24'h080000;
    mem[5]   = 24'h000005;
    mem[127] = 24'h00ABC0;

    applyStimulus(1, 1, 1, 0, 8'h00);
    applyStimulus(1, 1, 1, 0, 8'h00);
    checkOutput("reset_mar",     MAR, 24'd20);
    checkOutput("reset_en",      mem_EN, 24'd0);
    checkOutput("reset_req",     mem_req, 24'd0);
    checkOutput("reset_cs",      mem_CS, 24'd0);
    checkOutput("reset_valid",   instr_valid, 24'd0);
    checkOutput("reset_ir",      IR, 24'd0);
    checkOutput("reset_ipc",     instr_pc, 24'd0);
    checkOutput("reset_illegal", instr_illegal, 24'd0);
    checkOutput("reset_mar2",    MAR2, 24'd127);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("idle_en",  mem_EN, 24'd0);
    checkOutput("idle_req", mem_req, 24'd0);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("issue1_mar",  MAR, 24'd20);
    checkOutput("issue1_en",   mem_EN, 24'd1);
    checkOutput("issue1_req",  mem_req, 24'd1);
    checkOutput("issue1_mar2", MAR2, 24'd127);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("capture1_valid", instr_valid, 24'd0);
    checkOutput("capture1_en",    mem_EN, 24'd0);
    checkOutput("capture1_req",   mem_req, 24'd0);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("hold1_valid",   instr_valid, 24'd1);
    checkOutput("hold1_ir",      IR, 24'h0188F0);
    checkOutput("hold1_opcode",  opcode, 24'd3);
    checkOutput("hold1_rd",      rd, 24'd1);
    checkOutput("hold1_operand", operand, 24'd30);
    checkOutput("hold1_mode",    mode, 24'd0);
    checkOutput("hold1_ipc",     instr_pc, 24'd20);
    checkOutput("hold1_illegal", instr_illegal, 24'd0);
    checkOutput("hold1_mar",     MAR, 24'd21);
    checkOutput("wrap_ipc2",     instr_pc2, 24'd127);
    checkOutput("wrap_ir2",      IR2, 24'h00ABC0);
    checkOutput("wrap_mar2",     MAR2, 24'd0);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("issue2_mar",   MAR, 24'd21);
    checkOutput("issue2_valid", instr_valid, 24'd0);
    checkOutput("issue2_en",    mem_EN, 24'd1);
    checkOutput("issue2_mar2",  MAR2, 24'd0);
    checkOutput("issue2_en2",   mem_EN2, 24'd1);

    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("stall_valid",   instr_valid, 24'd1);
    checkOutput("stall_ir",      IR, 24'h07FFFC);
    checkOutput("stall_ipc",     instr_pc, 24'd21);
    checkOutput("mode4_illegal", instr_illegal, 24'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 8'h00);
      checkOutput("stall_valid_n", instr_valid, 24'd1);
      checkOutput("stall_ir_n",    IR, 24'h07FFFC);
      checkOutput("stall_en_n",    mem_EN, 24'd0);
      checkOutput("stall_req_n",   mem_req, 24'd0);
    end
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("release_valid", instr_valid, 24'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 8'h00);
      checkOutput("nogrant_req", mem_req, 24'd1);
      checkOutput("nogrant_en",  mem_EN, 24'd0);
      checkOutput("nogrant_mar", MAR, 24'd22);
    end
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("grant_en",  mem_EN, 24'd1);
    checkOutput("grant_mar", MAR, 24'd22);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("grant_capture_valid", instr_valid, 24'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("grant_hold_valid", instr_valid, 24'd1);
    checkOutput("grant_hold_ir",    IR, 24'hF80000);
    checkOutput("opcode_illegal",   instr_illegal, 24'd1);
    checkOutput("grant_hold_ipc",   instr_pc, 24'd22);

    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("issue23_mar", MAR, 24'd23);
    applyStimulus(0, 1, 1, 1, 8'h18);
    checkOutput("redir_cap_valid",   instr_valid, 24'd0);
    checkOutput("redir_cap_illegal", instr_illegal, 24'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("redir_cap_mar",   MAR, 24'd24);
    checkOutput("redir_cap_valid2", instr_valid, 24'd0);
    checkOutput("redir_cap_ir",    IR, 24'hF80000);

    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 1, 8'h98);
    checkOutput("hold24_valid",   instr_valid, 24'd1);
    checkOutput("hold24_ir",      IR, 24'h080000);
    checkOutput("bit19_illegal",  instr_illegal, 24'd1);
    checkOutput("hold24_ipc",     instr_pc, 24'd24);
    checkOutput("hold24_mar",     MAR, 24'd25);
    applyStimulus(0, 1, 1, 1, 8'h05);
    checkOutput("redir_hold_mar",     MAR, 24'h18);
    checkOutput("redir_hold_valid",   instr_valid, 24'd0);
    checkOutput("redir_hold_illegal", instr_illegal, 24'd0);
    applyStimulus(0, 1, 1, 0, 8'h00);
    checkOutput("redir_issue_mar", MAR, 24'd5);
    checkOutput("redir_issue_en",  mem_EN, 24'd1);

    applyStimulus(0, 1, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 0, 8'h00);
    checkOutput("hold5_valid",   instr_valid, 24'd1);
    checkOutput("hold5_ir",      IR, 24'h000005);
    checkOutput("hold5_mode",    mode, 24'd5);
    checkOutput("mode5_illegal", instr_illegal, 24'd1);
    checkOutput("hold5_ipc",     instr_pc, 24'd5);

    applyStimulus(0, 1, 0, 1, 8'h40);
    checkOutput("midreset_valid", instr_valid, 24'd0);
    checkOutput("midreset_mar",   MAR, 24'd20);
    checkOutput("midreset_ir",    IR, 24'd0);
    checkOutput("midreset_ipc",   instr_pc, 24'd0);
    checkOutput("midreset_req",   mem_req, 24'd0);
    applyStimulus(0, 1, 0, 0, 8'h00);
    checkOutput("idle_redirect_mar", MAR, 24'd20);
    checkOutput("idle_redirect_req", mem_req, 24'd1);
    checkOutput("final_cs",          mem_CS, 24'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
